// File: rtl/hist_readout_sched.sv
// hist_readout_sched: reads the r2, r4 and r6 joint-histogram banks in that
// order and sends them out on one AXI-Stream master. A credit-limited FWFT
// FIFO with registered outputs absorbs read latency and back-pressure.
// Build option: define HRS_TLAST_PER_SRC_EN to put tlast on the last beat of
// every source (three packets). Without it, tlast marks only the end of the
// frame (one packet).
module hist_readout_sched #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [LEN_W-1:0]    src_len_i,
  input  logic [2:0]          src_done_i,
  output logic [2:0]          rd_en_o,
  input  logic [3*DATA_W-1:0] rd_data_i,
  input  logic [2:0]          rd_valid_i,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [1:0]          m_axis_tuser,
  output logic                busy_o,
  output logic                irq_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_READ, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        src;
    logic              last;
  } entry_t;

  state_t            state;
  logic [LEN_W-1:0]  len, issued, rx_cnt;
  logic [1:0]        src, rx_src;
  logic [2:0]        done_flag;
  logic [CW-1:0]     outstanding, st_cnt, fifo_count;
  logic              busy, irq;

  entry_t            mem [FIFO_DEPTH];
  entry_t            out_q, in_entry;
  logic              out_vld;
  logic [PW-1:0]     wr_ptr, rd_ptr;

  logic              req, push, pop, load_out, mem_wr, mem_rd, drain_done;
  logic              sel_valid, src_last, in_last;
  logic [DATA_W-1:0] sel_data;

  // Words held = backing store plus the output register.
  assign fifo_count = st_cnt + CW'(out_vld);

  // Issue a read only when a FIFO slot is guaranteed for the returning word.
  assign req = (state == S_READ) && (issued < len) &&
               (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH));
  assign rd_en_o = req ? (3'b001 << src) : 3'b000;

  // Returning data follows the receive pointer, which can trail the issue
  // source by the read latency. Other sources' valids are ignored.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    case (rx_src)
      2'd0: begin sel_valid = rd_valid_i[0]; sel_data = rd_data_i[0*DATA_W +: DATA_W]; end
      2'd1: begin sel_valid = rd_valid_i[1]; sel_data = rd_data_i[1*DATA_W +: DATA_W]; end
      2'd2: begin sel_valid = rd_valid_i[2]; sel_data = rd_data_i[2*DATA_W +: DATA_W]; end
      default: ;
    endcase
  end

  // Gating on outstanding drops stale valids after reset.
  assign push     = sel_valid && (outstanding != '0);
  assign src_last = (rx_cnt == len - 1'b1);
`ifdef HRS_TLAST_PER_SRC_EN
  assign in_last  = src_last;
`else
  // All sources share len, so the highest non-empty source is always r6.
  assign in_last  = src_last && (rx_src == 2'd2);
`endif
  assign in_entry = {sel_data, rx_src, in_last};

  assign pop      = out_vld && m_axis_tready;
  assign load_out = !out_vld || pop;
  assign mem_rd   = load_out && (st_cnt != '0);
  assign mem_wr   = push && !(load_out && (st_cnt == '0));

  // Frame is finished once nothing is in flight and the last word leaves now.
  assign drain_done = (outstanding == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  // Backing store, no reset needed: occupancy is tracked by st_cnt.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= in_entry;
  end

  // Output register refilled from the store, or directly from the input when the store is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      out_vld <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      st_cnt  <= '0;
    end else begin
      if (load_out) begin
        if (mem_rd) begin
          out_q   <= mem[rd_ptr];
          out_vld <= 1'b1;
          rd_ptr  <= rd_ptr + 1'b1;
        end else if (push) begin
          out_q   <= in_entry;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      st_cnt <= st_cnt + CW'(mem_wr) - CW'(mem_rd);
    end
  end

  // Sequencer: source order, counters, sticky done flags, busy and irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      len         <= '0;
      src         <= '0;
      issued      <= '0;
      rx_cnt      <= '0;
      rx_src      <= '0;
      outstanding <= '0;
      done_flag   <= '0;
      busy        <= 1'b0;
      irq         <= 1'b0;
    end else begin
      done_flag   <= ((state == S_ARM) ? 3'b000 : done_flag) | src_done_i;
      outstanding <= outstanding + CW'(req) - CW'(push);
      if (req) issued <= issued + 1'b1;
      if (push) begin
        if (src_last) begin
          rx_cnt <= '0;
          if (rx_src != 2'd2) rx_src <= rx_src + 1'b1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
      case (state)
        S_IDLE: if (start_i) begin
          state <= S_ARM;
          len   <= src_len_i;
          busy  <= 1'b1;
        end
        S_ARM: begin
          src    <= '0;
          issued <= '0;
          rx_cnt <= '0;
          rx_src <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: if (done_flag[src]) state <= S_READ;
        S_READ: if (issued >= len) begin
          issued <= '0;
          if (src == 2'd2) state <= S_DRAIN;
          else begin
            src   <= src + 1'b1;
            state <= S_WAIT;
          end
        end
        S_DRAIN: if (drain_done) begin
          state <= S_DONE;
          irq   <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          irq   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = out_q.data;
  assign m_axis_tuser  = out_q.src;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tvalid = out_vld;
  assign busy_o        = busy;
  assign irq_o         = irq;

endmodule

// File: tb/tb_hist_readout_sched.sv
// Bench for hist_readout_sched: fixed-latency bank model, beat monitor and
// a table of frame scenarios plus a mid-read reset sequence.
module tb_hist_readout_sched;
  localparam int DW = 32;
  localparam int LW = 12;
  localparam int HL = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic [LW-1:0]   src_len_i = '0;
  logic [2:0]      src_done_i = '0;
  logic [2:0]      rd_en_o;
  logic [3*DW-1:0] rd_data_i = '0;
  logic [2:0]      rd_valid_i = '0;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic            m_axis_tlast;
  logic [1:0]      m_axis_tuser;
  logic            busy_o, irq_o;

  always #5 clk = ~clk;

  hist_readout_sched #(.DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_len_i(src_len_i),
    .src_done_i(src_done_i), .rd_en_o(rd_en_o), .rd_data_i(rd_data_i),
    .rd_valid_i(rd_valid_i), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy_o(busy_o), .irq_o(irq_o)
  );

  typedef struct {
    int len;
    int rdy;        // 0: tready always 1, 1: pattern 1,0,0,1
    int order;      // 0: r2,r4,r6  1: r6,r4,r2  2: r2,r4,r6 widely spaced
    bit mid_start;  // extra start pulse while busy
    int exp_beats;
  } vec_t;

  vec_t tab [5];

  int total = 0, bad = 0, cyc = 0;
  int iss_cnt, hs_cnt, cred_max, hold_err, onehot_err, irq_cnt, irq_cyc, last_hs_cyc, tv_seen;
  int iss_k [3];
  int addr [3];
  int rdy_mode = 0;
  logic [DW-1:0] q_data [$];
  logic [1:0]    q_user [$];
  logic          q_last [$];
  logic          prev_stall = 1'b0;
  logic [34:0]   prev_beat = '0;
  logic [2:0]    req_s = '0;
  logic [2:0]    pv [HL];
  logic [3*DW-1:0] pd [HL];

  function automatic logic [31:0] bank_word(input int k, input int a);
    return 32'hB000_0000 + 32'(k << 24) + 32'(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    iss_cnt = 0; hs_cnt = 0; cred_max = 0; hold_err = 0; onehot_err = 0;
    irq_cnt = 0; irq_cyc = -1; last_hs_cyc = -100; tv_seen = 0; prev_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin iss_k[k] = 0; addr[k] = 0; end
    q_data.delete(); q_user.delete(); q_last.delete();
  endtask

  task automatic pulse(input logic [2:0] bits);
    @(posedge clk); #1 src_done_i = bits;
    @(posedge clk); #1 src_done_i = 3'b000;
  endtask

  // Bank model: fixed latency HL, sequential addresses per source; tready driver.
  initial begin
    for (int s = 0; s < HL; s++) begin pv[s] = '0; pd[s] = '0; end
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int s = HL-1; s > 0; s--) begin pv[s] = pv[s-1]; pd[s] = pd[s-1]; end
      pv[0] = req_s;
      pd[0] = '0;
      for (int k = 0; k < 3; k++)
        if (req_s[k]) begin
          pd[0][k*DW +: DW] = bank_word(k, addr[k]);
          addr[k]++;
        end
      rd_valid_i = pv[HL-1];
      rd_data_i  = pd[HL-1];
      m_axis_tready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    end
  end

  // Monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      req_s = rd_en_o;
      if (|rd_en_o) begin
        iss_cnt++;
        for (int k = 0; k < 3; k++) if (rd_en_o[k]) iss_k[k]++;
      end
      if (!$onehot0(rd_en_o)) onehot_err++;
      if (iss_cnt - hs_cnt > cred_max) cred_max = iss_cnt - hs_cnt;
      if (prev_stall && (!m_axis_tvalid || {m_axis_tdata, m_axis_tuser, m_axis_tlast} != prev_beat))
        hold_err++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      if (m_axis_tvalid) tv_seen++;
      if (m_axis_tvalid && m_axis_tready) begin
        q_data.push_back(m_axis_tdata);
        q_user.push_back(m_axis_tuser);
        q_last.push_back(m_axis_tlast);
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (irq_o) begin irq_cnt++; irq_cyc = cyc; end
    end
  end

  task automatic run_frame(input vec_t v);
    int t, k, a;
    logic el;
    clear_mon();
    rdy_mode = v.rdy;
    @(posedge clk); #1 start_i = 1'b1; src_len_i = LW'(v.len);
    @(negedge clk); chk("busy_before_start", busy_o, 0);
    @(posedge clk); #1 start_i = 1'b0; src_len_i = '0;
    @(negedge clk); chk("busy_rise", busy_o, 1);
    if (v.mid_start) begin
      @(posedge clk); #1 start_i = 1'b1; src_len_i = LW'(9);
      @(posedge clk); #1 start_i = 1'b0; src_len_i = '0;
    end
    case (v.order)
      0: begin pulse(3'b001); pulse(3'b010); pulse(3'b100); end
      1: begin pulse(3'b100); pulse(3'b010); pulse(3'b001); end
      default: begin
        pulse(3'b001); repeat (30) @(posedge clk);
        pulse(3'b010); repeat (30) @(posedge clk);
        pulse(3'b100);
      end
    endcase
    t = 0;
    while (irq_cnt == 0 && t < 3000) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("irq_count", irq_cnt, 1);
    chk("beat_count", q_data.size(), v.exp_beats);
    chk("rd_en_count", iss_cnt, v.exp_beats);
    if (v.len > 0)
      for (int b = 0; b < q_data.size() && b < v.exp_beats; b++) begin
        k = b / v.len;
        a = b % v.len;
`ifdef HRS_TLAST_PER_SRC_EN
        el = (a == v.len - 1);
`else
        el = (b == 3 * v.len - 1);
`endif
        chk($sformatf("beat%0d", b), {q_data[b], q_user[b], q_last[b]},
            {bank_word(k, a), 2'(k), el});
      end
    if (v.exp_beats > 0) chk("irq_after_last_beat", irq_cyc, last_hs_cyc + 1);
    chk("credit_le_4", cred_max <= 4, 1);
    chk("hold_while_stalled", hold_err, 0);
    chk("rd_en_onehot", onehot_err, 0);
    chk("busy_fall", busy_o, 0);
  endtask

  initial begin
    tab[0] = '{len: 8,  rdy: 0, order: 0, mid_start: 0, exp_beats: 24};
    tab[1] = '{len: 8,  rdy: 0, order: 1, mid_start: 0, exp_beats: 24};
    tab[2] = '{len: 16, rdy: 1, order: 0, mid_start: 0, exp_beats: 48};
    tab[3] = '{len: 0,  rdy: 0, order: 0, mid_start: 0, exp_beats: 0};
    tab[4] = '{len: 4,  rdy: 0, order: 2, mid_start: 1, exp_beats: 12};

    clear_mon();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {rd_en_o, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                          m_axis_tuser, busy_o, irq_o}, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(tab[i]);

    // Reset in the middle of reading r4 with reads still in flight.
    clear_mon();
    rdy_mode = 0;
    @(posedge clk); #1 start_i = 1'b1; src_len_i = LW'(8);
    @(posedge clk); #1 start_i = 1'b0; src_len_i = '0;
    pulse(3'b111);
    begin
      int t;
      t = 0;
      while (iss_k[1] < 3 && t < 300) begin @(posedge clk); t++; end
    end
    chk("reached_r4_read", iss_k[1] >= 3, 1);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_read_reset_outputs", {rd_en_o, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                                   m_axis_tuser, busy_o, irq_o}, 0);
    tv_seen = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("late_valid_dropped", tv_seen, 0);
    chk("idle_after_reset", {busy_o, irq_o, rd_en_o}, 0);

    run_frame(tab[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
